// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin arbiter and access sequencer between the CPU
// load/store port (m0) and a debug/loader port (m1) sharing one single-port
// data memory. One access is in flight at a time; the memory is driven for
// MEM_LAT cycles, then the winner gets a one-cycle done pulse.
module dm_arbiter #(
  parameter int MEM_LAT = 1,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_done,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_done,
  output logic [DATA_W-1:0] m1_rdata,
  input  logic              m1_lock,
  output logic              cpu_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

  state_t            state, state_nx;
  logic              last;      // 1: m1 was granted most recently
  logic              win;       // 1: current access belongs to m1
  logic [3:0]        lat_cnt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] m0_rdata_q;
  logic [DATA_W-1:0] m1_rdata_q;

  logic elig0, elig1, any_elig, pick1;

  // m0 is locked out by m1_lock; on a tie the requester not granted last wins
  assign elig0    = m0_req & ~m1_lock;
  assign elig1    = m1_req;
  assign any_elig = elig0 | elig1;
  assign pick1    = elig1 & (~elig0 | ~last);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (any_elig) state_nx = ACCESS;
      ACCESS:  if (lat_cnt == 4'd0) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs: grants only in IDLE, memory driven only in ACCESS, done in RESP
  always_comb begin
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    m0_done   = 1'b0;
    m1_done   = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state)
      IDLE: begin
        m0_gnt = any_elig & ~pick1;
        m1_gnt = pick1;
      end
      ACCESS: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
      end
      RESP: begin
        m0_done = ~win;
        m1_done = win;
      end
      default: ;
    endcase
  end

  assign cpu_stall = m0_req & ~m0_done;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

  // Request capture at grant, latency countdown, read data capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last       <= 1'b1;
      win        <= 1'b0;
      lat_cnt    <= 4'd0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      if (state == IDLE && any_elig) begin
        last    <= pick1;
        win     <= pick1;
        we_q    <= pick1 ? m1_we    : m0_we;
        addr_q  <= pick1 ? m1_addr  : m0_addr;
        wdata_q <= pick1 ? m1_wdata : m0_wdata;
        lat_cnt <= LAT_LOAD;
      end
      if (state == ACCESS) begin
        if (lat_cnt != 4'd0) begin
          lat_cnt <= lat_cnt - 4'd1;
        end else if (!we_q) begin
          if (win) m1_rdata_q <= mem_rdata;
          else     m0_rdata_q <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: one instance at MEM_LAT=2 checked by a scoreboard
// plus a vector table, one at MEM_LAT=1 for the single-cycle boundary.
module tb_dm_arbiter;
  localparam int LAT_A = 2;
  localparam int LAT_B = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // ---------------- instance A (MEM_LAT=2) ----------------
  logic        rst_a;
  logic        a0_req, a0_we, a0_gnt, a0_done;
  logic [31:0] a0_addr, a0_wdata, a0_rdata;
  logic        a1_req, a1_we, a1_gnt, a1_done;
  logic [31:0] a1_addr, a1_wdata, a1_rdata;
  logic        a_lock, a_stall, a_en, a_we;
  logic [31:0] a_addr, a_wdata, a_rdata;

  dm_arbiter #(.MEM_LAT(LAT_A), .ADDR_W(32), .DATA_W(32)) ua (
    .clk(clk), .rst(rst_a),
    .m0_req(a0_req), .m0_we(a0_we), .m0_addr(a0_addr), .m0_wdata(a0_wdata),
    .m0_gnt(a0_gnt), .m0_done(a0_done), .m0_rdata(a0_rdata),
    .m1_req(a1_req), .m1_we(a1_we), .m1_addr(a1_addr), .m1_wdata(a1_wdata),
    .m1_gnt(a1_gnt), .m1_done(a1_done), .m1_rdata(a1_rdata),
    .m1_lock(a_lock), .cpu_stall(a_stall),
    .mem_en(a_en), .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wdata),
    .mem_rdata(a_rdata)
  );

  logic [31:0] mem_a   [256];
  logic [31:0] ref_mem [256];
  assign a_rdata = mem_a[a_addr[7:0]];
  always @(posedge clk) if (a_en && a_we) mem_a[a_addr[7:0]] <= a_wdata;

  // ---------------- instance B (MEM_LAT=1) ----------------
  logic        rst_b;
  logic        b0_req, b0_we, b0_gnt, b0_done;
  logic [31:0] b0_addr, b0_wdata, b0_rdata;
  logic        b1_req, b1_we, b1_gnt, b1_done;
  logic [31:0] b1_addr, b1_wdata, b1_rdata;
  logic        b_lock, b_stall, b_en, b_we;
  logic [31:0] b_addr, b_wdata, b_rdata;

  dm_arbiter #(.MEM_LAT(LAT_B), .ADDR_W(32), .DATA_W(32)) ub (
    .clk(clk), .rst(rst_b),
    .m0_req(b0_req), .m0_we(b0_we), .m0_addr(b0_addr), .m0_wdata(b0_wdata),
    .m0_gnt(b0_gnt), .m0_done(b0_done), .m0_rdata(b0_rdata),
    .m1_req(b1_req), .m1_we(b1_we), .m1_addr(b1_addr), .m1_wdata(b1_wdata),
    .m1_gnt(b1_gnt), .m1_done(b1_done), .m1_rdata(b1_rdata),
    .m1_lock(b_lock), .cpu_stall(b_stall),
    .mem_en(b_en), .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata),
    .mem_rdata(b_rdata)
  );

  assign b_rdata = (b_addr == 32'h8) ? 32'h0BAD_F00D : 32'h0;

  // ---------------- scoreboard for A ----------------
  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] exp;
    int          t;
  } sb_t;

  sb_t         sb[$];
  logic [31:0] last_rd [2];
  int          last_gnt_t = -100;

  // Push expectations at grant, pop and compare at done, watch the memory bus
  always @(negedge clk) begin : mon
    sb_t         e;
    bit          p;
    bit          in_acc;
    logic [31:0] ad;
    if (!rst_a) begin
      if (a0_done && a1_done) fail("both done");
      else if (a0_done || a1_done) begin
        if (sb.size() == 0) fail("unexpected done");
        else begin
          e = sb.pop_front();
          chk1("done port", a1_done, e.port);
          chk("done latency", cyc - e.t, LAT_A + 1);
          chk("done rdata", e.port ? a1_rdata : a0_rdata, e.exp);
        end
      end
      if (sb.size() > 0) begin
        e = sb[0];
        in_acc = (cyc > e.t) && (cyc <= e.t + LAT_A);
        chk1("mem_en window", a_en, in_acc);
        if (in_acc) begin
          chk1("mem_we", a_we, e.we);
          chk("mem_addr", a_addr, e.addr);
        end else chk1("mem_we outside access", a_we, 1'b0);
      end else begin
        chk1("mem_en idle", a_en, 1'b0);
        chk1("mem_we idle", a_we, 1'b0);
      end
      if (a0_gnt || a1_gnt) begin
        chk1("single gnt", a0_gnt & a1_gnt, 1'b0);
        if (cyc <= last_gnt_t + LAT_A + 1) fail("gnt while busy");
        if (a_lock) chk1("m0 gnt under lock", a0_gnt, 1'b0);
        p  = a1_gnt;
        ad = p ? a1_addr : a0_addr;
        e.port = p;
        e.we   = p ? a1_we : a0_we;
        e.addr = ad;
        e.t    = cyc;
        if (e.we) begin
          ref_mem[ad[7:0]] = p ? a1_wdata : a0_wdata;
          e.exp = last_rd[p];
        end else begin
          e.exp = ref_mem[ad[7:0]];
          last_rd[p] = e.exp;
        end
        sb.push_back(e);
        last_gnt_t = cyc;
      end
    end
  end

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (sb.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) fail("timeout waiting for done");
  endtask

  task automatic wait_any_gnt(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (a0_gnt || a1_gnt) begin ok = 1'b1; break; end
    end
    if (!ok) fail("timeout waiting for gnt");
  endtask

  task automatic issue(input bit p, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    bit ok = 1'b0;
    @(posedge clk); #1;
    if (p) begin a1_req = 1'b1; a1_we = we; a1_addr = addr; a1_wdata = wdata; end
    else   begin a0_req = 1'b1; a0_we = we; a0_addr = addr; a0_wdata = wdata; end
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (p ? a1_gnt : a0_gnt) begin ok = 1'b1; break; end
    end
    if (!ok) fail("timeout in issue");
    @(posedge clk); #1;
    a0_req = 1'b0;
    a1_req = 1'b0;
    wait_idle();
  endtask

  typedef struct {
    bit          p;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    vec_t vt [6];
    bit   ok;
    int   prev, t0, en_cnt;
    bit   exp_p, got;

    vt[0] = '{1'b1, 1'b1, 32'h10, 32'h1234_5678, 32'hA000_0008};
    vt[1] = '{1'b1, 1'b0, 32'h10, 32'h0,         32'h1234_5678};
    vt[2] = '{1'b0, 1'b1, 32'h20, 32'hCAFE_0020, 32'hDEAD_BEEF};
    vt[3] = '{1'b0, 1'b0, 32'h20, 32'h0,         32'hCAFE_0020};
    vt[4] = '{1'b1, 1'b0, 32'h40, 32'h0,         32'hDEAD_BEEF};
    vt[5] = '{1'b0, 1'b0, 32'h10, 32'h0,         32'h1234_5678};

    for (int i = 0; i < 256; i++) begin
      mem_a[i]   = 32'hA000_0000 | i;
      ref_mem[i] = 32'hA000_0000 | i;
    end
    mem_a[8'h40]   = 32'hDEAD_BEEF;
    ref_mem[8'h40] = 32'hDEAD_BEEF;
    last_rd[0] = '0;
    last_rd[1] = '0;

    rst_a = 1'b1; rst_b = 1'b1;
    a0_req = 0; a0_we = 0; a0_addr = '0; a0_wdata = '0;
    a1_req = 0; a1_we = 0; a1_addr = '0; a1_wdata = '0; a_lock = 0;
    b0_req = 0; b0_we = 0; b0_addr = '0; b0_wdata = '0;
    b1_req = 0; b1_we = 0; b1_addr = '0; b1_wdata = '0; b_lock = 0;

    // reset state
    repeat (3) @(negedge clk);
    chk1("rst m0_gnt", a0_gnt, 1'b0);
    chk1("rst m1_gnt", a1_gnt, 1'b0);
    chk1("rst m0_done", a0_done, 1'b0);
    chk1("rst m1_done", a1_done, 1'b0);
    chk("rst m0_rdata", a0_rdata, 32'h0);
    chk("rst m1_rdata", a1_rdata, 32'h0);
    chk1("rst mem_en", a_en, 1'b0);
    chk1("rst mem_we", a_we, 1'b0);
    chk("rst mem_addr", a_addr, 32'h0);
    chk("rst mem_wdata", a_wdata, 32'h0);
    chk1("rst cpu_stall", a_stall, 1'b0);
    chk1("rst b mem_en", b_en, 1'b0);
    @(posedge clk); #1;
    rst_a = 1'b0; rst_b = 1'b0;

    // both request continuously: m0 first, then alternation every LAT+2
    @(posedge clk); #1;
    a0_req = 1'b1; a0_we = 1'b0; a0_addr = 32'h04;
    a1_req = 1'b1; a1_we = 1'b0; a1_addr = 32'h08;
    prev  = -1;
    exp_p = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_any_gnt(ok);
      if (ok) begin
        chk1("rr winner", a1_gnt, exp_p);
        if (prev >= 0) chk("rr spacing", cyc - prev, LAT_A + 2);
        prev  = cyc;
        exp_p = ~exp_p;
      end
    end
    @(posedge clk); #1;
    a0_req = 1'b0; a1_req = 1'b0;
    wait_idle();

    // m0 read of 0x40 held until done: stall high until the done cycle
    @(posedge clk); #1;
    a0_req = 1'b1; a0_we = 1'b0; a0_addr = 32'h40;
    got = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (a0_done) begin
        chk1("stall in done cycle", a_stall, 1'b0);
        chk("m0 read 0x40", a0_rdata, 32'hDEAD_BEEF);
        got = 1'b1;
        break;
      end else chk1("stall while pending", a_stall, 1'b1);
    end
    if (!got) fail("m0 read never done");
    #1 a0_req = 1'b0;
    wait_idle();

    // vector table
    for (int i = 0; i < 6; i++) begin
      issue(vt[i].p, vt[i].we, vt[i].addr, vt[i].wdata);
      chk($sformatf("vec%0d rdata", i), vt[i].p ? a1_rdata : a0_rdata, vt[i].exp_rdata);
    end

    // lock: only m1 served, stall held, m0 wins first IDLE after release
    @(posedge clk); #1;
    a_lock = 1'b1;
    a0_req = 1'b1; a0_we = 1'b0; a0_addr = 32'h40;
    a1_req = 1'b1; a1_we = 1'b0; a1_addr = 32'h20;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      chk1("lock m0_gnt", a0_gnt, 1'b0);
      chk1("lock stall", a_stall, 1'b1);
    end
    @(posedge clk); #1;
    a_lock = 1'b0;
    wait_any_gnt(ok);
    if (ok) chk1("first gnt after unlock is m0", a0_gnt, 1'b1);
    @(posedge clk); #1;
    a0_req = 1'b0; a1_req = 1'b0;
    wait_idle();

    // reset in the first ACCESS cycle drops the access
    @(posedge clk); #1;
    a0_req = 1'b1; a0_we = 1'b0; a0_addr = 32'h04;
    wait_any_gnt(ok);
    @(posedge clk); #1;
    a0_req = 1'b0;
    @(negedge clk);
    chk1("first access cycle mem_en", a_en, 1'b1);
    #2;
    rst_a = 1'b1;
    sb.delete();
    last_rd[0] = '0;
    last_rd[1] = '0;
    last_gnt_t = -100;
    #1;
    chk1("async reset mem_en", a_en, 1'b0);
    chk("reset clears m0_rdata", a0_rdata, 32'h0);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk1("no done in reset", a0_done | a1_done, 1'b0);
    end
    @(posedge clk); #1;
    rst_a = 1'b0;
    repeat (4) @(negedge clk);
    chk1("no done after reset", a0_done | a1_done, 1'b0);
    @(posedge clk); #1;
    a0_req = 1'b1; a0_addr = 32'h0C;
    a1_req = 1'b1; a1_addr = 32'h40;
    wait_any_gnt(ok);
    if (ok) chk1("tie after reset goes to m0", a0_gnt, 1'b1);
    @(posedge clk); #1;
    a0_req = 1'b0; a1_req = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);

    // MEM_LAT=1: one enable cycle, done two cycles after the grant
    @(posedge clk); #1;
    b0_req = 1'b1; b0_we = 1'b0; b0_addr = 32'h8;
    got = 1'b0;
    t0  = -1;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (b0_gnt) begin t0 = cyc; break; end
    end
    if (t0 < 0) fail("b gnt timeout");
    @(posedge clk); #1;
    b0_req = 1'b0;
    en_cnt = 0;
    for (int n = 0; n < 6; n++) begin
      if (n > 0) @(negedge clk);
      else @(negedge clk);
      if (b_en) begin
        en_cnt++;
        chk("b mem_en cycle", cyc - t0, 1);
      end
      if (b0_done) begin
        chk("b done latency", cyc - t0, 2);
        chk("b rdata", b0_rdata, 32'h0BAD_F00D);
        got = 1'b1;
      end
    end
    chk("b mem_en cycles", en_cnt, 1);
    chk1("b done seen", got, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-requester arbiter and access sequencer for the single-port data memory of the two-stage CPU. The CPU load/store port (m0) and a debug/loader port (m1) share one memory, with round-robin arbitration and one outstanding access at a time. The block drives the memory for a configurable number of cycles and returns read data or a write completion to the winning requester. It also produces a stall signal that freezes the CPU pipeline while its access is pending.

## Interface
- MEM_LAT, 1, cycles `mem_en` is held per access; read data is sampled in the last of them (legal 1..15)
- ADDR_W, 32, address width
- DATA_W, 32, data width

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- m0_req  in  1  CPU requests an access
- m0_we  in  1  CPU access is a write
- m0_addr  in  ADDR_W  CPU address
- m0_wdata  in  DATA_W  CPU write data
- m0_gnt  out  1  CPU request accepted this cycle (combinational)
- m0_done  out  1  CPU access complete, one-cycle pulse
- m0_rdata  out  DATA_W  CPU read data, valid with `m0_done` on reads
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_done, m1_rdata  same as m0_*, for the debug port
- m1_lock  in  1  while high, m0 is never granted
- cpu_stall  out  1  `m0_req & ~m0_done`
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any eligible request is present, pick a winner and assert its `gnt` combinationally.
  - On the clock edge: latch `we`, `addr` and `wdata` into internal registers, store the winner id, load `lat_cnt = MEM_LAT-1`, go to ACCESS.
  - With no eligible request, stay in IDLE.
- Eligibility: m1 is eligible when `m1_req`. m0 is eligible when `m0_req & ~m1_lock`.
- Round-robin rule: when both are eligible, grant the requester that was not granted last. The `last` register updates on every grant.
- ACCESS:
  - `mem_en=1`; `mem_we`, `mem_addr` and `mem_wdata` come from the latched registers.
  - `lat_cnt` decrements each cycle.
  - When `lat_cnt==0`: capture `mem_rdata` into `rdata_q` if the access is a read, then go to RESP.
- RESP:
  - Pulse `done` for the winner for one cycle.
  - The winner's `rdata` output shows `rdata_q`; a write leaves `rdata_q` unchanged.
  - Go to IDLE.
- Outside ACCESS, `mem_en`, `mem_we`, `mem_addr` and `mem_wdata` are all 0.
- Requesters must hold `req` and their fields stable until `gnt`. Fields are ignored after the grant edge.
- A requester may keep `req` high after `done` to issue back-to-back accesses. It is rearbitrated in IDLE like any other request.
- `m1_lock` changing during ACCESS does not abort an in-flight m0 access.
- The `rdata` outputs hold their last value between accesses.

## Timing
- Reset values: state=IDLE, `last`=m1 (so m0 wins the first tie), `lat_cnt`=0, `rdata_q`=0, all outputs 0.
- Reset asserted mid-access: the access is dropped immediately, no `done` is issued, and `mem_en` goes to 0 asynchronously.
- Latency:
  - grant at cycle T (IDLE)
  - `mem_en` during T+1 .. T+MEM_LAT
  - `done` at T+MEM_LAT+1
  - next grant possible at T+MEM_LAT+2
- Throughput: one access per MEM_LAT+2 cycles.
- No grant is issued in ACCESS or RESP, even if requests are pending.
- `cpu_stall` is high from the first cycle `m0_req` is seen, through ACCESS, and low in the `m0_done` cycle. It is also high for the whole time m0 is locked out by `m1_lock`.
- `lat_cnt` is $clog2(16) = 4 bits wide and never wraps. It is reloaded only in IDLE.

## Test plan
- Read via m0, MEM_LAT=2:
  - Stimulus: memory word 0x40 preloaded with 0xDEADBEEF; m0 reads addr 0x40.
  - Required: `m0_gnt` at T; `mem_en` at T+1..T+2; `m0_done=1` and `m0_rdata=0xDEADBEEF` at T+3; `cpu_stall` low at T+3.
- Simultaneous requests after reset:
  - Stimulus: m0 and m1 both request continuously.
  - Required: grants alternate m0, m1, m0, m1 with exactly MEM_LAT+2 cycles between grants.
- Write then read through m1:
  - Stimulus: m1 writes 0x12345678 to 0x10, then reads 0x10.
  - Required: `m1_done` with `m1_rdata=0x12345678`; `mem_we=1` only during the write's ACCESS cycles.
- Lock:
  - Stimulus: `m1_lock=1` with m0 and m1 requesting for 20 cycles.
  - Required: only m1 is granted; `cpu_stall` stays 1; m0 is granted in the first IDLE after lock drops.
- Reset mid-ACCESS:
  - Stimulus: assert `rst` in the first ACCESS cycle.
  - Required: `mem_en` goes to 0 the same cycle; no `done` pulse; after release, m0 wins a tie.
- MEM_LAT=1 boundary:
  - Stimulus: MEM_LAT=1, single read.
  - Required: `mem_en` is high for exactly one cycle; `done` comes 2 cycles after the grant.
